// File: rtl/sm83_pkg.sv
// Shared SM83 types and constants used by the fetch stage and its opcode
// length decoder (also reused by debugger and tracer tooling).
package sm83_pkg;

    typedef logic [7:0]  instr_t;
    typedef logic [15:0] addr_t;

    typedef enum logic [2:0] {
        FETCH_OP,
        FETCH_CB,
        FETCH_LO,
        FETCH_HI,
        HOLD,
        DRAIN
    } fetch_state_t;

    typedef enum logic [1:0] {
        IMM_0,
        IMM_8,
        IMM_16
    } imm_len_t;

    localparam instr_t OPC_CB_PREFIX = 8'hCB;

endpackage

// File: rtl/sm83_instr_len.sv
// Combinational SM83 opcode classifier: number of immediate bytes that follow
// an unprefixed opcode, and whether the opcode is in the illegal set.
module sm83_instr_len
    import sm83_pkg::*;
(
    input  instr_t   opcode,
    output imm_len_t imm_len,
    output logic     illegal
);

    always_comb begin
        imm_len = IMM_0;
        illegal = 1'b0;
        case (opcode)
            8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
            8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
            8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
            8'hE0, 8'hF0, 8'hE8, 8'hF8:
                imm_len = IMM_8;
            8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
            8'hC2, 8'hC3, 8'hCA, 8'hD2, 8'hDA,
            8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC, 8'hEA, 8'hFA:
                imm_len = IMM_16;
            8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
            8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD:
                illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/sm83_fetch.sv
// SM83 instruction fetch: reads opcode, CB suffix and immediates one byte at a
// time, then holds a complete bundle for decode. SM83_HALT_BUG_EN adds halt_bug.
module sm83_fetch
    import sm83_pkg::*;
#(
    parameter addr_t RESET_PC = 16'h0100
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_instr,
    output logic        out_is_cb,
    output logic [15:0] out_imm,
    output logic [1:0]  out_len,
    output logic        out_illegal,
    output logic [15:0] out_pc,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        stall
`ifdef SM83_HALT_BUG_EN
    ,
    input  logic        halt_bug
`endif
);

    fetch_state_t state_q, state_d;
    addr_t        pc_q, pc_d;
    addr_t        mem_addr_q, mem_addr_d;
    logic         mem_rd_q, mem_rd_d;
    instr_t       instr_q, instr_d;
    logic         is_cb_q, is_cb_d;
    addr_t        imm_q, imm_d;
    logic [1:0]   len_q, len_d;
    logic         illegal_q, illegal_d;
    addr_t        opc_pc_q, opc_pc_d;
    imm_len_t     imm_len_q, imm_len_d;

    imm_len_t     lut_imm_len;
    logic         lut_illegal;
    addr_t        op_step;
    logic         ack_take;

    sm83_instr_len u_instr_len (
        .opcode  (mem_rdata),
        .imm_len (lut_imm_len),
        .illegal (lut_illegal)
    );

`ifdef SM83_HALT_BUG_EN
    assign op_step = halt_bug ? 16'h0000 : 16'h0001;
`else
    assign op_step = 16'h0001;
`endif

    assign ack_take = mem_rd_q & mem_ack;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = mem_rd_q;
        instr_d    = instr_q;
        is_cb_d    = is_cb_q;
        imm_d      = imm_q;
        len_d      = len_q;
        illegal_d  = illegal_q;
        opc_pc_d   = opc_pc_q;
        imm_len_d  = imm_len_q;

        // Redirect overrides everything; an ack landing in the same cycle is dropped.
        if (redirect) begin
            pc_d    = redirect_pc;
            state_d = (mem_rd_q && !mem_ack) ? DRAIN : FETCH_OP;
        end else begin
            case (state_q)
                FETCH_OP: if (ack_take) begin
                    opc_pc_d  = pc_q;
                    pc_d      = pc_q + op_step;
                    instr_d   = mem_rdata;
                    is_cb_d   = 1'b0;
                    imm_d     = '0;
                    illegal_d = 1'b0;
                    imm_len_d = IMM_0;
                    if (mem_rdata == OPC_CB_PREFIX) begin
                        len_d   = 2'd2;
                        state_d = FETCH_CB;
                    end else begin
                        imm_len_d = lut_imm_len;
                        illegal_d = lut_illegal;
                        case (lut_imm_len)
                            IMM_8: begin
                                len_d   = 2'd2;
                                state_d = FETCH_LO;
                            end
                            IMM_16: begin
                                len_d   = 2'd3;
                                state_d = FETCH_LO;
                            end
                            default: begin
                                len_d   = 2'd1;
                                state_d = HOLD;
                            end
                        endcase
                    end
                end
                FETCH_CB: if (ack_take) begin
                    instr_d = mem_rdata;
                    is_cb_d = 1'b1;
                    pc_d    = pc_q + 16'h0001;
                    state_d = HOLD;
                end
                FETCH_LO: if (ack_take) begin
                    imm_d[7:0] = mem_rdata;
                    pc_d       = pc_q + 16'h0001;
                    state_d    = (imm_len_q == IMM_16) ? FETCH_HI : HOLD;
                end
                FETCH_HI: if (ack_take) begin
                    imm_d[15:8] = mem_rdata;
                    pc_d        = pc_q + 16'h0001;
                    state_d     = HOLD;
                end
                HOLD: if (out_ready) begin
                    state_d = FETCH_OP;
                end
                DRAIN: if (mem_ack) begin
                    state_d = FETCH_OP;
                end
                default: state_d = FETCH_OP;
            endcase
        end

        // An outstanding read keeps its request and address until acked; otherwise
        // the next request is issued early so each byte costs only one cycle.
        if (mem_rd_q && !mem_ack) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = mem_addr_q;
        end else begin
            mem_addr_d = pc_d;
            mem_rd_d   = (state_d inside {FETCH_CB, FETCH_LO, FETCH_HI}) ||
                         ((state_d == FETCH_OP) && !stall);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH_OP;
            pc_q       <= RESET_PC;
            mem_addr_q <= RESET_PC;
            mem_rd_q   <= 1'b0;
            instr_q    <= '0;
            is_cb_q    <= 1'b0;
            imm_q      <= '0;
            len_q      <= '0;
            illegal_q  <= 1'b0;
            opc_pc_q   <= '0;
            imm_len_q  <= IMM_0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            instr_q    <= instr_d;
            is_cb_q    <= is_cb_d;
            imm_q      <= imm_d;
            len_q      <= len_d;
            illegal_q  <= illegal_d;
            opc_pc_q   <= opc_pc_d;
            imm_len_q  <= imm_len_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_rd      = mem_rd_q;
    assign out_valid   = (state_q == HOLD);
    assign out_instr   = instr_q;
    assign out_is_cb   = is_cb_q;
    assign out_imm     = imm_q;
    assign out_len     = len_q;
    assign out_illegal = illegal_q;
    assign out_pc      = opc_pc_q;

endmodule

// File: tb/tb_sm83_fetch.sv
// Bench for sm83_fetch: directed scenarios plus randomized bus latency, ready,
// stall and redirects, checked against an instruction-level reference model.
module tb_sm83_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_instr;
    logic        out_is_cb;
    logic [15:0] out_imm;
    logic [1:0]  out_len;
    logic        out_illegal;
    logic [15:0] out_pc;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        stall = 1'b0;

    sm83_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_is_cb   (out_is_cb),
        .out_imm     (out_imm),
        .out_len     (out_len),
        .out_illegal (out_illegal),
        .out_pc      (out_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  instr;
        logic        cb;
        logic [15:0] imm;
        logic [1:0]  len;
        logic        ill;
        logic [15:0] pc;
    } bundle_t;

    logic [7:0]  mem [0:65535];
    logic [15:0] reads[$];
    bundle_t     bundles[$];
    logic [15:0] exp_pc;
    int          lat = 0;
    int          wait_cnt = 0;
    int          vec_cnt = 0;
    int          miss_cnt = 0;

    logic [7:0] tab8  [0:24] = '{8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
                                 8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'hC6, 8'hCE, 8'hD6,
                                 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE, 8'hE0, 8'hF0, 8'hE8, 8'hF8};
    logic [7:0] tab16 [0:16] = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hC3, 8'hCA,
                                 8'hD2, 8'hDA, 8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC, 8'hEA, 8'hFA};
    logic [7:0] tabil [0:10] = '{8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
                                 8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int ref_imm_bytes(input logic [7:0] op);
        int n = 0;
        for (int i = 0; i < 25; i++) if (tab8[i] == op) n = 1;
        for (int i = 0; i < 17; i++) if (tab16[i] == op) n = 2;
        return n;
    endfunction

    function automatic logic ref_illegal(input logic [7:0] op);
        logic r = 1'b0;
        for (int i = 0; i < 11; i++) if (tabil[i] == op) r = 1'b1;
        return r;
    endfunction

    // Instruction-level model: decode the bytes at exp_pc and advance by the length.
    task automatic model_check();
        logic [15:0] p1, p2;
        logic [7:0]  op, e_instr;
        logic [15:0] e_imm;
        logic        e_cb, e_ill;
        int          n;
        p1 = exp_pc + 16'd1;
        p2 = exp_pc + 16'd2;
        op = mem[exp_pc];
        e_cb = (op == 8'hCB);
        e_ill = 1'b0;
        e_imm = 16'h0000;
        if (e_cb) begin
            e_instr = mem[p1];
            n = 1;
        end else begin
            e_instr = op;
            e_ill = ref_illegal(op);
            n = ref_imm_bytes(op);
            if (n == 1) e_imm = {8'h00, mem[p1]};
            if (n == 2) e_imm = {mem[p2], mem[p1]};
        end
        check("bundle_pc", out_pc, exp_pc);
        check("bundle_instr", out_instr, e_instr);
        check("bundle_cb", out_is_cb, e_cb);
        check("bundle_imm", out_imm, e_imm);
        check("bundle_len", out_len, 32'(n + 1));
        check("bundle_illegal", out_illegal, e_ill);
        $display("bundle pc=%h instr=%h cb=%0d imm=%h len=%0d ill=%0d",
                 out_pc, out_instr, out_is_cb, out_imm, out_len, out_illegal);
        exp_pc = exp_pc + 16'(n + 1);
    endtask

    task automatic cycle();
        logic        hs, prev_rd, prev_ack;
        logic [15:0] prev_addr;
        bundle_t     b;
        if (mem_rd) begin
            mem_ack   = (wait_cnt >= lat);
            mem_rdata = mem[mem_addr];
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 8'h00;
        end
        hs = out_valid && out_ready;
        if (mem_rd && mem_ack) reads.push_back(mem_addr);
        if (hs) begin
            b.instr = out_instr; b.cb = out_is_cb; b.imm = out_imm;
            b.len = out_len; b.ill = out_illegal; b.pc = out_pc;
            bundles.push_back(b);
            model_check();
        end
        if (redirect) exp_pc = redirect_pc;
        prev_rd = mem_rd;
        prev_ack = mem_ack;
        prev_addr = mem_addr;
        @(negedge clk);
        if (prev_rd && !prev_ack) begin
            wait_cnt++;
            check("rd_held", mem_rd, 1);
            check("addr_stable", mem_addr, prev_addr);
        end else begin
            wait_cnt = 0;
        end
    endtask

    task automatic wait_bundles(input int n);
        for (int i = 0; i < 300 && bundles.size() < n; i++) cycle();
        check("bundle_timeout", bundles.size() >= n, 1);
    endtask

    task automatic wait_reads(input int n);
        for (int i = 0; i < 300 && reads.size() < n; i++) cycle();
        check("read_timeout", reads.size() >= n, 1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 300 && !out_valid; i++) cycle();
        check("valid_timeout", out_valid, 1);
    endtask

    task automatic do_redirect(input logic [15:0] target);
        redirect = 1'b1;
        redirect_pc = target;
        cycle();
        redirect = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        // directed program at 0100: NOP; LD BC,1234; SWAP A; LD A,55; LD B,77
        mem[16'h0100] = 8'h00;
        mem[16'h0101] = 8'h01; mem[16'h0102] = 8'h34; mem[16'h0103] = 8'h12;
        mem[16'h0104] = 8'hCB; mem[16'h0105] = 8'h37;
        mem[16'h0106] = 8'h3E; mem[16'h0107] = 8'h55;
        mem[16'h0108] = 8'h06; mem[16'h0109] = 8'h77;
        mem[16'h0038] = 8'h00; mem[16'h0039] = 8'h00;
        mem[16'hFFFF] = 8'hC6; mem[16'h0000] = 8'hAB;
        mem[16'h0001] = 8'h00; mem[16'h0200] = 8'h00;
        exp_pc = 16'h0100;

        repeat (3) @(negedge clk);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_valid", out_valid, 0);
        check("rst_addr", mem_addr, 16'h0100);
        check("rst_instr", out_instr, 0);
        check("rst_imm", out_imm, 0);
        check("rst_len", out_len, 0);
        check("rst_pc", out_pc, 0);
        rst_n = 1'b1;

        out_ready = 1'b1;
        wait_bundles(1);
        check("nop_read", reads[0], 16'h0100);
        check("nop_len", bundles[0].len, 1);
        wait_bundles(3);
        check("ld_reads", {reads[1], reads[3]}, {16'h0101, 16'h0103});
        check("ld_imm", bundles[1].imm, 16'h1234);
        check("cb_flag", bundles[2].cb, 1);
        check("cb_instr", bundles[2].instr, 8'h37);

        out_ready = 1'b0;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", out_valid, 1);
            check("hold_imm", out_imm, 16'h0055);
            check("hold_no_rd", mem_rd, 0);
            cycle();
        end
        out_ready = 1'b1;
        lat = 3;
        wait_reads(9);
        check("after_hold_read", reads[8], 16'h0108);

        // redirect while the immediate read of 0109 is still waiting for ack
        do_redirect(16'h0038);
        check("drain_rd", mem_rd, 1);
        check("drain_addr", mem_addr, 16'h0109);
        wait_reads(11);
        check("drained_read", reads[9], 16'h0109);
        check("redirect_read", reads[10], 16'h0038);
        wait_bundles(5);
        check("redirect_bundle", bundles[4].pc, 16'h0038);

        out_ready = 1'b0;
        wait_valid();
        do_redirect(16'hFFFF);
        out_ready = 1'b1;
        wait_bundles(6);
        check("wrap_pc", bundles[5].pc, 16'hFFFF);
        check("wrap_imm", bundles[5].imm, 16'h00AB);
        check("wrap_read", reads[reads.size() - 1], 16'h0000);

        out_ready = 1'b0;
        wait_valid();
        stall = 1'b1;
        do_redirect(16'h0200);
        for (int i = 0; i < 6; i++) begin
            check("stall_no_rd", mem_rd, 0);
            cycle();
        end
        stall = 1'b0;
        out_ready = 1'b1;
        wait_bundles(7);
        check("stall_bundle", bundles[6].pc, 16'h0200);

        for (int i = 0; i < 1500; i++) begin
            out_ready = ($urandom_range(3) != 0);
            lat = $urandom_range(2);
            stall = ($urandom_range(7) == 0);
            redirect = ($urandom_range(19) == 0);
            redirect_pc = 16'($urandom);
            cycle();
        end
        redirect = 1'b0;
        stall = 1'b0;
        out_ready = 1'b1;
        repeat (10) cycle();
        check("random_progress", bundles.size() > 50, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/sm83_fetch.md
Name: sm83_fetch

Overview:
- Instruction fetch stage sitting directly upstream of the SM83 decode/control stage.
- Fetches the opcode at PC from the memory bus, resolves the CB prefix, and collects 0/1/2 immediate bytes.
- Presents a complete instruction (instr_t opcode, CB flag, imm16, length, PC of opcode) to decode over a valid/ready handshake.
- Accepts PC redirects from execute (jumps, calls, returns, RST, interrupts) and a stall from HALT/STOP.

Parameters:
- RESET_PC, 16'h0100, PC value loaded on reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mem_addr  out  16  bus read address, stable while mem_rd=1
- mem_rd  out  1  read request, held until mem_ack
- mem_rdata  in  8  read data, valid when mem_ack=1
- mem_ack  in  1  one-cycle read completion
- out_valid  out  1  instruction bundle valid
- out_ready  in  1  decode accepts bundle
- out_instr  out  8  opcode byte as sm83_pkg::instr_t; for CB instructions, the byte after CB
- out_is_cb  out  1  instruction was CB-prefixed
- out_imm  out  16  immediate: {msb,lsb} as addr_t; d8 in lsb with msb=0
- out_len  out  2  total instruction length in bytes (1..3)
- out_illegal  out  1  opcode is in the SM83 illegal set
- out_pc  out  16  address of the first byte of the instruction
- redirect  in  1  load new PC, flush current fetch
- redirect_pc  in  16  new PC
- stall  in  1  HALT/STOP: do not start new opcode fetches

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC; state=FETCH_OP; mem_rd=0; out_valid=0; out_instr=0; out_is_cb=0; out_imm=0; out_len=0; out_illegal=0; out_pc=0; mem_addr=RESET_PC.
- States:
  - FETCH_OP: mem_rd=1 when stall=0; address=pc; on ack, latch opcode, set out_pc=pc, pc+=1.
    - CB -> FETCH_CB.
    - imm length 0 -> HOLD.
    - imm length 1 or 2 -> FETCH_LO.
  - FETCH_CB: read pc; on ack, latch opcode, set is_cb=1, pc+=1 -> HOLD.
  - FETCH_LO: read pc; on ack, imm.lsb=data, pc+=1.
    - 2-byte immediate -> FETCH_HI.
    - otherwise -> HOLD.
  - FETCH_HI: read pc; on ack, imm.msb=data, pc+=1 -> HOLD.
  - HOLD: out_valid=1; all out_* stable. On out_valid&out_ready -> FETCH_OP next cycle with out_valid=0.
  - DRAIN: mem_rd held; wait for ack, discard data -> FETCH_OP.
- Throughput: minimum 1 cycle per byte plus 1 cycle in HOLD. No fetch overlap.
- Length table (1-byte immediate): 06 0E 16 1E 26 2E 36 3E 18 20 28 30 38 C6 CE D6 DE E6 EE F6 FE E0 F0 E8 F8.
- Length table (2-byte immediate): 01 11 21 31 08 C2 C3 CA D2 DA C4 CC CD D4 DC EA FA.
- CB instructions: out_len=2, imm=0.
- Illegal opcodes: D3 DB DD E3 E4 EB EC ED F4 FC FD. out_len=1, out_illegal=1, no immediate.
- pc wraps FFFF->0000 with no flag.
- Stall: only gates a new opcode request in FETCH_OP when mem_rd is not yet asserted. Byte fetches in progress complete, and HOLD is unaffected.
- Redirect has highest priority in any state:
  - pc<=redirect_pc; out_valid<=0.
  - If mem_rd=1 and mem_ack=0 that cycle -> DRAIN; otherwise -> FETCH_OP.
  - Redirect coincident with ack: data discarded, pc not incremented.
  - Redirect coincident with an out_ready handshake: the handshake completes (decode consumed it) and the redirect still applies.
- mem_rd is never dropped before ack (bus rule), including across redirect.

Optional Feature:
- Macro: SM83_HALT_BUG_EN.
- Defined: adds input halt_bug (1). When halt_bug=1 on the cycle the FETCH_OP ack occurs, pc is not incremented, so the opcode byte is read twice.
- Not defined: port absent; pc always increments on ack.

Decomposition:
- sm83_pkg additions: fetch_state_t enum (FETCH_OP, FETCH_CB, FETCH_LO, FETCH_HI, HOLD, DRAIN).
- sm83_pkg additions: OPC_CB_PREFIX=8'hCB constant.
- sm83_pkg additions: imm_len_t (IMM_0, IMM_8, IMM_16).
- Sub-module sm83_instr_len: combinational opcode -> {imm_len_t, illegal}, reusable by the debugger and tracer.

Test Plan:
- Reset, memory 0100:00 (NOP), ready=1 -> read 0100, bundle instr=00, len=1, pc=0100; next read at 0101.
- 0100:01 34 12 (LD BC,d16) -> three reads 0100..0102, imm=1234, len=3; next read at 0103.
- 0100:CB 37 (SWAP A) -> is_cb=1, instr=37, len=2, imm=0.
- Hold ready=0 for 5 cycles on 3E 55 -> valid and imm=0055 stay constant, no mem_rd; ready=1 -> next read at 0102.
- Ack delayed 3 cycles during FETCH_LO, redirect to 0038 mid-wait -> mem_rd held until ack, data dropped, next read 0038, no valid.
- pc=FFFF opcode C6 -> immediate read at 0000; stall=1 with pc=0200 -> no mem_rd until stall=0.
